gpu_mem_responder: RTL and testbench

//  Avalon-MM byte-wide memory slave that answers the GPU's m1 master port.
//  - Serves pixel, voxel and palette buffer traffic for simulation and for small on-chip builds.
//  - Pipelined reads with a fixed latency plus waitrequest backpressure.
//  - Bounded outstanding-read window.
//  - Sits between gpu_controller's m1 and a BASE_ADDR-mapped on-chip RAM.

---
 rtl/gpu_mem_responder_pkg.sv | 18 +
 rtl/gpu_mem_read_pipe.sv | 30 +++
 rtl/gpu_mem_responder.sv | 108 ++++++++++
 tb/tb_gpu_mem_responder.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_mem_responder_pkg.sv
// Shared types for the GPU memory responder: response beat type and stall LFSR helpers.
package gpu_mem_responder_pkg;

  localparam int GPU_MEM_DATA_W = 8;

  typedef struct packed {
    logic                      valid;
    logic [GPU_MEM_DATA_W-1:0] data;
  } mem_rsp_t;

  localparam logic [15:0] GPU_MEM_LFSR_SEED = 16'hACE1;

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward the MSB.
  function automatic logic [15:0] gpu_mem_lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/gpu_mem_read_pipe.sv
// Fixed-latency read return pipe: a shift register of response beats, flushed by reset.
module gpu_mem_read_pipe
  import gpu_mem_responder_pkg::*;
#(
  parameter int unsigned LATENCY = 2
) (
  input  logic     clock,
  input  logic     reset,
  input  mem_rsp_t issue,
  output mem_rsp_t retire
);

  mem_rsp_t stage [LATENCY];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= issue;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign retire = stage[LATENCY-1];

endmodule

// File: rtl/gpu_mem_responder.sv
// Avalon-MM byte-wide on-chip memory slave for the GPU m1 port with pipelined reads.
// Optional random stall injection: define GPU_MEM_STALL_EN.
module gpu_mem_responder
  import gpu_mem_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned DEPTH        = 65536,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned MAX_PENDING  = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [31:0]                      s1_address,
  input  logic                             s1_read,
  input  logic                             s1_write,
  input  logic [GPU_MEM_DATA_W-1:0]        s1_writedata,
  output logic                             s1_waitrequest,
  output logic [GPU_MEM_DATA_W-1:0]        s1_readdata,
  output logic                             s1_readdatavalid,
  output logic [15:0]                      err_count,
  output logic [$clog2(MAX_PENDING+1)-1:0] pending
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = $clog2(MAX_PENDING+1);

  logic [GPU_MEM_DATA_W-1:0] mem [DEPTH];

  logic [31:0]   off;
  logic          in_range;
  logic [AW-1:0] idx;
  logic          stall;
  logic          accept;
  logic          acc_rd;
  logic          acc_wr;
  logic          err_now;
  mem_rsp_t      issue;
  mem_rsp_t      retire;

  assign off      = s1_address - BASE_ADDR;
  assign in_range = off < 32'(DEPTH);
  assign idx      = off[AW-1:0];

`ifdef GPU_MEM_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clock) begin
    if (reset) lfsr <= GPU_MEM_LFSR_SEED;
    else       lfsr <= gpu_mem_lfsr_next(lfsr);
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign s1_waitrequest = (pending == PW'(MAX_PENDING)) | stall;

  // A simultaneous read+write performs only the write and is flagged as an error.
  always_comb begin
    accept  = (s1_read | s1_write) & ~s1_waitrequest;
    acc_wr  = accept & s1_write;
    acc_rd  = accept & s1_read & ~s1_write;
    err_now = accept & (~in_range | (s1_read & s1_write));
    issue   = '0;
    issue.valid = acc_rd;
    issue.data  = in_range ? mem[idx] : '0;
  end

  always_ff @(posedge clock) begin
    if (!reset && acc_wr && in_range) begin
      mem[idx] <= s1_writedata;
    end
  end

  gpu_mem_read_pipe #(
    .LATENCY(READ_LATENCY)
  ) u_read_pipe (
    .clock (clock),
    .reset (reset),
    .issue (issue),
    .retire(retire)
  );

  assign s1_readdatavalid = retire.valid;
  assign s1_readdata      = retire.data;

  always_ff @(posedge clock) begin
    if (reset) begin
      pending <= '0;
    end else begin
      case ({acc_rd, retire.valid})
        2'b10:   pending <= pending + PW'(1);
        2'b01:   pending <= pending - PW'(1);
        default: pending <= pending;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err_count <= '0;
    end else if (err_now && err_count != '1) begin
      err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_gpu_mem_responder.sv
// Self-checking bench for gpu_mem_responder: scoreboard of expected read returns against two instances.
module tb_gpu_mem_responder;

  localparam logic [31:0] BASE0  = 32'h4000_0000;
  localparam int          DEPTH0 = 65536;
  localparam int          LAT    = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rd    [2];
  logic        wr    [2];
  logic [31:0] addr  [2];
  logic [7:0]  wd    [2];
  logic        wq    [2];
  logic        rdv   [2];
  logic [7:0]  rdata [2];
  logic [15:0] err   [2];
  logic [2:0]  pend0;
  logic        pend1;

  int cyc = 0;

  typedef struct {
    logic [7:0] d;
    int         c;
  } rsp_t;

  rsp_t exp0[$];
  rsp_t exp1[$];
  rsp_t got0[$];
  rsp_t got1[$];

  int n_cmp = 0;
  int n_bad = 0;

  gpu_mem_responder #(
    .BASE_ADDR   (BASE0),
    .DEPTH       (DEPTH0),
    .READ_LATENCY(LAT),
    .MAX_PENDING (4)
  ) dut0 (
    .clock           (clock),
    .reset           (reset),
    .s1_address      (addr[0]),
    .s1_read         (rd[0]),
    .s1_write        (wr[0]),
    .s1_writedata    (wd[0]),
    .s1_waitrequest  (wq[0]),
    .s1_readdata     (rdata[0]),
    .s1_readdatavalid(rdv[0]),
    .err_count       (err[0]),
    .pending         (pend0)
  );

  gpu_mem_responder #(
    .BASE_ADDR   (32'h0000_0000),
    .DEPTH       (256),
    .READ_LATENCY(LAT),
    .MAX_PENDING (1)
  ) dut1 (
    .clock           (clock),
    .reset           (reset),
    .s1_address      (addr[1]),
    .s1_read         (rd[1]),
    .s1_write        (wr[1]),
    .s1_writedata    (wd[1]),
    .s1_waitrequest  (wq[1]),
    .s1_readdata     (rdata[1]),
    .s1_readdatavalid(rdv[1]),
    .err_count       (err[1]),
    .pending         (pend1)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Called at a negedge; holds the command until accepted, returns at the negedge after acceptance.
  task automatic bus_cmd(input int sel, input bit r, input bit w, input logic [31:0] a,
                         input logic [7:0] d, input logic [7:0] e, output int waits);
    bit done;
    done  = 1'b0;
    waits = 0;
    rd[sel] = r; wr[sel] = w; addr[sel] = a; wd[sel] = d;
    for (int i = 0; i < 64 && !done; i++) begin
      if (!wq[sel]) begin
        if (r && !w) begin
          if (sel == 0) exp0.push_back('{e, cyc});
          else          exp1.push_back('{e, cyc});
        end
        done = 1'b1;
      end else begin
        waits++;
      end
      @(negedge clock);
    end
    rd[sel] = 1'b0; wr[sel] = 1'b0;
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: dut%0d waitrequest held 64 cycles, required acceptance", sel);
    end
  endtask

  task automatic wait_got(input int sel, input int n);
    for (int i = 0; i < 40; i++) begin
      if ((sel == 0 ? got0.size() : got1.size()) >= n) break;
      @(negedge clock);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clock);
      if (rdv[0] === 1'b1) got0.push_back('{rdata[0], cyc});
      if (rdv[1] === 1'b1) got1.push_back('{rdata[1], cyc});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    for (int s = 0; s < 2; s++) begin
      n_cmp++;
      if ({rdv[s], rdata[s], wq[s], err[s]} !== 26'd0) begin
        n_bad++;
        $display("FAIL reset_outputs: dut%0d rdv=%b rdata=%h wq=%b err=%h, required all 0",
                 s, rdv[s], rdata[s], wq[s], err[s]);
      end
    end
    n_cmp++;
    if (pend0 !== 3'd0 || pend1 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_pending: pend0=%0d pend1=%0d, required 0", pend0, pend1);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_write_read();
    int w;
    rsp_t e, g;
    bus_cmd(0, 0, 1, BASE0 + 32'd3, 8'hA5, 8'h00, w);
    bus_cmd(0, 1, 0, BASE0 + 32'd3, 8'h00, 8'hA5, w);
    n_cmp++;
    if (pend0 !== 3'd1) begin
      n_bad++; $display("FAIL wr_rd_pending_1: got %0d, required 1", pend0);
    end
    wait_got(0, 1);
    @(negedge clock);
    n_cmp++;
    if (pend0 !== 3'd0) begin
      n_bad++; $display("FAIL wr_rd_pending_0: got %0d, required 0", pend0);
    end
    n_cmp++;
    if (got0.size() != 1 || exp0.size() != 1) begin
      n_bad++; $display("FAIL wr_rd_count: got %0d returns, required 1", got0.size());
    end else begin
      e = exp0.pop_front(); g = got0.pop_front();
      n_cmp++;
      if (g.d !== e.d) begin
        n_bad++; $display("FAIL wr_rd_data: got %h, required %h", g.d, e.d);
      end
      n_cmp++;
      if (g.c - e.c != LAT) begin
        n_bad++; $display("FAIL wr_rd_latency: got %0d, required %0d", g.c - e.c, LAT);
      end
    end
    exp0.delete(); got0.delete();
  endtask

  task automatic test_back_to_back();
    int w, wsum, c0;
    rsp_t e, g;
    for (int i = 0; i < 8; i++) bus_cmd(0, 0, 1, BASE0 + 32'(i), 8'h10 + 8'(i), 8'h00, w);
    wsum = 0;
    for (int i = 0; i < 8; i++) begin
      bus_cmd(0, 1, 0, BASE0 + 32'(i), 8'h00, 8'h10 + 8'(i), w);
      wsum += w;
    end
`ifndef GPU_MEM_STALL_EN
    n_cmp++;
    if (wsum != 0) begin
      n_bad++; $display("FAIL b2b_waitrequest: got %0d wait cycles, required 0", wsum);
    end
`endif
    wait_got(0, 8);
    n_cmp++;
    if (got0.size() != 8) begin
      n_bad++; $display("FAIL b2b_count: got %0d returns, required 8", got0.size());
    end
    c0 = (got0.size() > 0) ? got0[0].c : 0;
    for (int i = 0; i < 8 && got0.size() > 0 && exp0.size() > 0; i++) begin
      e = exp0.pop_front(); g = got0.pop_front();
      n_cmp++;
      if (g.d !== e.d) begin
        n_bad++; $display("FAIL b2b_data[%0d]: got %h, required %h", i, g.d, e.d);
      end
      n_cmp++;
      if (g.c - e.c != LAT) begin
        n_bad++; $display("FAIL b2b_latency[%0d]: got %0d, required %0d", i, g.c - e.c, LAT);
      end
`ifndef GPU_MEM_STALL_EN
      n_cmp++;
      if (g.c != c0 + i) begin
        n_bad++; $display("FAIL b2b_consecutive[%0d]: cycle %0d, required %0d", i, g.c, c0 + i);
      end
`endif
    end
    exp0.delete(); got0.delete();
  endtask

  task automatic test_max_pending1();
    int w;
    int waits [3];
    rsp_t e, g;
    for (int i = 0; i < 3; i++) bus_cmd(1, 0, 1, 32'(i), 8'hC0 + 8'(i), 8'h00, w);
    for (int i = 0; i < 3; i++) bus_cmd(1, 1, 0, 32'(i), 8'h00, 8'hC0 + 8'(i), waits[i]);
    for (int i = 1; i < 3; i++) begin
      n_cmp++;
`ifndef GPU_MEM_STALL_EN
      if (waits[i] != LAT) begin
`else
      if (waits[i] < LAT) begin
`endif
        n_bad++; $display("FAIL mp1_wait[%0d]: got %0d wait cycles, required %0d", i, waits[i], LAT);
      end
    end
    wait_got(1, 3);
    n_cmp++;
    if (got1.size() != 3) begin
      n_bad++; $display("FAIL mp1_count: got %0d returns, required 3", got1.size());
    end
    while (got1.size() > 0 && exp1.size() > 0) begin
      e = exp1.pop_front(); g = got1.pop_front();
      n_cmp++;
      if (g.d !== e.d || g.c - e.c != LAT) begin
        n_bad++; $display("FAIL mp1_return: got %h after %0d, required %h after %0d", g.d, g.c - e.c, e.d, LAT);
      end
    end
    exp1.delete(); got1.delete();
  endtask

  task automatic test_out_of_range();
    int w;
    rsp_t e, g;
    bus_cmd(0, 0, 1, BASE0 + 32'hFFFF, 8'h77, 8'h00, w);
    bus_cmd(0, 1, 0, BASE0 + 32'(DEPTH0), 8'h00, 8'h00, w);
    bus_cmd(0, 0, 1, BASE0 - 32'd1, 8'h99, 8'h00, w);
    bus_cmd(0, 1, 0, BASE0 + 32'hFFFF, 8'h00, 8'h77, w);
    bus_cmd(0, 1, 0, BASE0, 8'h00, 8'h10, w);
    wait_got(0, 3);
    n_cmp++;
    if (got0.size() != 3) begin
      n_bad++; $display("FAIL oor_count: got %0d returns, required 3", got0.size());
    end
    for (int i = 0; i < 3 && got0.size() > 0 && exp0.size() > 0; i++) begin
      e = exp0.pop_front(); g = got0.pop_front();
      n_cmp++;
      if (g.d !== e.d || g.c - e.c != LAT) begin
        n_bad++; $display("FAIL oor_return[%0d]: got %h after %0d, required %h after %0d", i, g.d, g.c - e.c, e.d, LAT);
      end
    end
    n_cmp++;
    if (err[0] !== 16'd2) begin
      n_bad++; $display("FAIL oor_err_count: got %0d, required 2", err[0]);
    end
    exp0.delete(); got0.delete();
  endtask

  task automatic test_illegal();
    int w;
    rsp_t e, g;
    bus_cmd(0, 1, 1, BASE0 + 32'd5, 8'h3C, 8'h00, w);
    repeat (6) @(negedge clock);
    n_cmp++;
    if (got0.size() != 0 || pend0 !== 3'd0) begin
      n_bad++; $display("FAIL illegal_no_read: got %0d returns pending %0d, required 0 and 0", got0.size(), pend0);
    end
    n_cmp++;
    if (err[0] !== 16'd3) begin
      n_bad++; $display("FAIL illegal_err_count: got %0d, required 3", err[0]);
    end
    bus_cmd(0, 1, 0, BASE0 + 32'd5, 8'h00, 8'h3C, w);
    wait_got(0, 1);
    n_cmp++;
    if (got0.size() != 1) begin
      n_bad++; $display("FAIL illegal_readback_count: got %0d, required 1", got0.size());
    end else begin
      e = exp0.pop_front(); g = got0.pop_front();
      n_cmp++;
      if (g.d !== e.d) begin
        n_bad++; $display("FAIL illegal_write_data: got %h, required %h", g.d, e.d);
      end
    end
    exp0.delete(); got0.delete();
  endtask

  task automatic test_reset_flush();
    int w;
    rsp_t e, g;
    bus_cmd(0, 1, 0, BASE0 + 32'd3, 8'h00, 8'h13, w);
    bus_cmd(0, 1, 0, BASE0 + 32'd4, 8'h00, 8'h14, w);
    // The first read is already on the bus in this cycle; the second is still in the pipe.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n_cmp++;
    if (pend0 !== 3'd0 || wq[0] !== 1'b0 || rdv[0] !== 1'b0) begin
      n_bad++; $display("FAIL flush_state: pending=%0d wq=%b rdv=%b, required 0 0 0", pend0, wq[0], rdv[0]);
    end
    repeat (6) @(negedge clock);
    n_cmp++;
    if (got0.size() != 1) begin
      n_bad++; $display("FAIL flush_returns: got %0d returns, required 1", got0.size());
    end
    if (got0.size() > 0 && exp0.size() > 0) begin
      e = exp0.pop_front(); g = got0.pop_front();
      n_cmp++;
      if (g.d !== e.d) begin
        n_bad++; $display("FAIL flush_first_data: got %h, required %h", g.d, e.d);
      end
    end
    exp0.delete(); got0.delete();
    bus_cmd(0, 1, 0, BASE0 + 32'd3, 8'h00, 8'h13, w);
    wait_got(0, 1);
    n_cmp++;
    if (got0.size() != 1 || exp0.size() != 1) begin
      n_bad++; $display("FAIL flush_retained_count: got %0d, required 1", got0.size());
    end else begin
      e = exp0.pop_front(); g = got0.pop_front();
      n_cmp++;
      if (g.d !== e.d) begin
        n_bad++; $display("FAIL flush_retained_data: got %h, required %h", g.d, e.d);
      end
    end
    exp0.delete(); got0.delete();
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      rd[s] = 1'b0; wr[s] = 1'b0; addr[s] = '0; wd[s] = '0;
    end
    fork
      monitor();
    join_none
    @(negedge clock);
    test_reset();
    test_write_read();
    test_back_to_back();
    test_max_pending1();
    test_out_of_range();
    test_illegal();
    test_reset_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
